// File: rtl/pwm_cfg_arbiter_pkg.sv
// pwm_cfg_arbiter_pkg: shared widths, FSM state encoding and index-width helper
package pwm_cfg_arbiter_pkg;
    localparam int DEF_CH_IDX_WIDTH  = 3;
    localparam int DEF_COUNTER_WIDTH = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;
    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pwm_cfg_arbiter_if.sv
// pwm_cfg_arbiter_if: requester-side valid/ready config bus
//   req_valid / req_ready : per-requester handshake
//   req_ch_index, req_period, req_duty : packed, requester i at [i*W +: W]
//   master = requesters, slave = arbiter
interface pwm_cfg_arbiter_if import pwm_cfg_arbiter_pkg::*; #(
    parameter int NUM_REQ       = 2,
    parameter int CH_IDX_WIDTH  = DEF_CH_IDX_WIDTH,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*CH_IDX_WIDTH-1:0]  req_ch_index;
    logic [NUM_REQ*COUNTER_WIDTH-1:0] req_period;
    logic [NUM_REQ*COUNTER_WIDTH-1:0] req_duty;
    modport master (output req_valid, req_ch_index, req_period, req_duty, input req_ready);
    modport slave  (input req_valid, req_ch_index, req_period, req_duty, output req_ready);
endinterface

// File: rtl/pwm_cfg_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
//   req          : request vector
//   ptr          : highest-priority index this round
//   grant_onehot : one-hot winner, grant_idx : winner index, any : some request present
module rr_arbiter import pwm_cfg_arbiter_pkg::*; #(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    always_comb begin
        int j;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j -= N;
            if (!any && req[IW'(j)]) begin
                any                  = 1'b1;
                grant_onehot[IW'(j)] = 1'b1;
                grant_idx            = IW'(j);
            end
        end
    end
endmodule

// File: rtl/pwm_cfg_arbiter.sv
// pwm_cfg_arbiter: round-robin sharing of the PWM config port with validation and strobe gap
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus              : requester valid/ready bus (slave side)
//   pwm_cfg_*        : config to the PWM generator, sampled only on pwm_cfg_strobe
//   grant_id         : requester of the last issued or rejected request
//   cfg_error        : pulse when an accepted request had period 0
//   busy             : FSM not in IDLE
module pwm_cfg_arbiter import pwm_cfg_arbiter_pkg::*; #(
    parameter int NUM_REQ       = 2,
    parameter int CH_IDX_WIDTH  = DEF_CH_IDX_WIDTH,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int MIN_GAP       = 1,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pwm_cfg_arbiter_if.slave         bus,
    output logic [CH_IDX_WIDTH-1:0]  pwm_cfg_ch_index,
    output logic [COUNTER_WIDTH-1:0] pwm_cfg_period,
    output logic [COUNTER_WIDTH-1:0] pwm_cfg_duty,
    output logic                     pwm_cfg_strobe,
    output logic [IW-1:0]            grant_id,
    output logic                     cfg_error,
    output logic                     busy
);
    state_t                   state;
    logic [7:0]               gap_cnt;
    logic [IW-1:0]            rr_ptr;
    logic [IW-1:0]            win_idx;
    logic [NUM_REQ-1:0]       win_oh;
    logic                     win_any;
    logic [CH_IDX_WIDTH-1:0]  win_ch;
    logic [COUNTER_WIDTH-1:0] win_per;
    logic [COUNTER_WIDTH-1:0] win_duty;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req          (bus.req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (win_oh),
        .grant_idx    (win_idx),
        .any          (win_any)
    );

    assign win_ch   = bus.req_ch_index[win_idx*CH_IDX_WIDTH +: CH_IDX_WIDTH];
    assign win_per  = bus.req_period[win_idx*COUNTER_WIDTH +: COUNTER_WIDTH];
    assign win_duty = bus.req_duty[win_idx*COUNTER_WIDTH +: COUNTER_WIDTH];
    // ready is gated by rst_n so nothing looks accepted while reset is held
    assign bus.req_ready = (rst_n && state == IDLE) ? win_oh : '0;

    // Outputs are registered at the accept edge so they appear in the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            gap_cnt          <= '0;
            rr_ptr           <= '0;
            pwm_cfg_ch_index <= '0;
            pwm_cfg_period   <= '0;
            pwm_cfg_duty     <= '0;
            pwm_cfg_strobe   <= 1'b0;
            grant_id         <= '0;
            cfg_error        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            pwm_cfg_strobe <= 1'b0;
            cfg_error      <= 1'b0;
            case (state)
                IDLE: if (win_any) begin
                    state    <= ISSUE;
                    busy     <= 1'b1;
                    grant_id <= win_idx;
                    rr_ptr   <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    if (win_per == '0) begin
                        cfg_error <= 1'b1;
                    end else begin
                        pwm_cfg_strobe   <= 1'b1;
                        pwm_cfg_ch_index <= win_ch;
                        pwm_cfg_period   <= win_per;
                        pwm_cfg_duty     <= (win_duty > win_per) ? win_per : win_duty;
                    end
                end
                ISSUE: begin
                    state   <= (MIN_GAP == 0) ? IDLE : GAP;
                    busy    <= (MIN_GAP != 0);
                    gap_cnt <= 8'(MIN_GAP - 1);
                end
                GAP: if (gap_cnt == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// tb_pwm_cfg_arbiter: directed checks of arbitration, validation, gap timing and reset abort
module tb_pwm_cfg_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    pwm_cfg_arbiter_if #(.NUM_REQ(2), .CH_IDX_WIDTH(3), .COUNTER_WIDTH(16)) ifa ();
    pwm_cfg_arbiter_if #(.NUM_REQ(4), .CH_IDX_WIDTH(3), .COUNTER_WIDTH(16)) ifb ();

    logic [2:0]  a_ch, b_ch;
    logic [15:0] a_per, a_duty, b_per, b_duty;
    logic        a_stb, a_err, a_busy, b_stb, b_err, b_busy;
    logic        a_gid;
    logic [1:0]  b_gid;

    pwm_cfg_arbiter #(.NUM_REQ(2), .CH_IDX_WIDTH(3), .COUNTER_WIDTH(16), .MIN_GAP(1)) dut (
        .clk (clk), .rst_n (rst_n), .bus (ifa.slave),
        .pwm_cfg_ch_index (a_ch), .pwm_cfg_period (a_per), .pwm_cfg_duty (a_duty),
        .pwm_cfg_strobe (a_stb), .grant_id (a_gid), .cfg_error (a_err), .busy (a_busy)
    );

    pwm_cfg_arbiter #(.NUM_REQ(4), .CH_IDX_WIDTH(3), .COUNTER_WIDTH(16), .MIN_GAP(0)) dut4 (
        .clk (clk), .rst_n (rst_n), .bus (ifb.slave),
        .pwm_cfg_ch_index (b_ch), .pwm_cfg_period (b_per), .pwm_cfg_duty (b_duty),
        .pwm_cfg_strobe (b_stb), .grant_id (b_gid), .cfg_error (b_err), .busy (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic req_a(input int i, input logic v, input logic [2:0] ch, input logic [15:0] per, input logic [15:0] duty);
        ifa.req_valid[i]             = v;
        ifa.req_ch_index[i*3 +: 3]   = ch;
        ifa.req_period[i*16 +: 16]   = per;
        ifa.req_duty[i*16 +: 16]     = duty;
    endtask

    task automatic req_b(input int i, input logic v, input logic [2:0] ch, input logic [15:0] per, input logic [15:0] duty);
        ifb.req_valid[i]             = v;
        ifb.req_ch_index[i*3 +: 3]   = ch;
        ifb.req_period[i*16 +: 16]   = per;
        ifb.req_duty[i*16 +: 16]     = duty;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.req_valid = '0; ifa.req_ch_index = '0; ifa.req_period = '0; ifa.req_duty = '0;
        ifb.req_valid = '0; ifb.req_ch_index = '0; ifb.req_period = '0; ifb.req_duty = '0;
        repeat (2) @(negedge clk);
        check("rst_stb", a_stb, 0);
        check("rst_err", a_err, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ch", a_ch, 0);
        check("rst_per", a_per, 0);
        check("rst_duty", a_duty, 0);
        check("rst_gid", a_gid, 0);
        rst_n = 1'b1;

        // single request
        req_a(0, 1, 3'd2, 16'd1000, 16'd250);
        #1 check("t1_ready", ifa.req_ready, 2'b01);
        check("t1_idle_busy", a_busy, 0);
        @(negedge clk);
        ifa.req_valid[0] = 1'b0;
        check("t1_stb", a_stb, 1);
        check("t1_ch", a_ch, 2);
        check("t1_per", a_per, 1000);
        check("t1_duty", a_duty, 250);
        check("t1_gid", a_gid, 0);
        check("t1_err", a_err, 0);
        check("t1_busy", a_busy, 1);
        check("t1_ready_issue", ifa.req_ready, 0);
        @(negedge clk);
        check("t1_gap_stb", a_stb, 0);
        check("t1_gap_busy", a_busy, 1);
        @(negedge clk);
        check("t1_end_busy", a_busy, 0);
        check("t1_hold_per", a_per, 1000);

        // two requesters held valid: alternate 0,1,0,1 with strobes 3 cycles apart
        pulse_reset;
        req_a(0, 1, 3'd1, 16'd10, 16'd5);
        req_a(1, 1, 3'd5, 16'd20, 16'd7);
        for (int k = 0; k < 12; k++) begin
            if (k == 11) ifa.req_valid = '0;
            check($sformatf("t2_stb_%0d", k), a_stb, (k % 3 == 1));
            if (k % 3 == 1) begin
                check($sformatf("t2_gid_%0d", k), a_gid, ((k - 1) / 3) % 2);
                check($sformatf("t2_ch_%0d", k), a_ch, (((k - 1) / 3) % 2 == 1) ? 5 : 1);
            end
            @(negedge clk);
        end

        // duty clamp, then zero-period rejection
        req_a(1, 1, 3'd3, 16'd100, 16'd500);
        #1 check("t3_ready", ifa.req_ready, 2'b10);
        @(negedge clk);
        ifa.req_valid[1] = 1'b0;
        check("t3_stb", a_stb, 1);
        check("t3_duty_clamp", a_duty, 100);
        check("t3_per", a_per, 100);
        check("t3_gid", a_gid, 1);
        repeat (2) @(negedge clk);
        req_a(0, 1, 3'd6, 16'd0, 16'd9);
        #1 check("t3b_ready", ifa.req_ready, 2'b01);
        @(negedge clk);
        ifa.req_valid[0] = 1'b0;
        check("t3b_err", a_err, 1);
        check("t3b_stb", a_stb, 0);
        check("t3b_ch_hold", a_ch, 3);
        check("t3b_per_hold", a_per, 100);
        check("t3b_duty_hold", a_duty, 100);
        check("t3b_gid", a_gid, 0);
        check("t3b_busy", a_busy, 1);
        @(negedge clk);
        check("t3b_err_pulse", a_err, 0);
        @(negedge clk);

        // request arriving during ISSUE/GAP waits for IDLE; duty == period passes
        req_a(1, 1, 3'd4, 16'd50, 16'd50);
        @(negedge clk);
        ifa.req_valid[1] = 1'b0;
        check("t4_stb1", a_stb, 1);
        check("t4_duty_eq", a_duty, 50);
        req_a(0, 1, 3'd7, 16'd300, 16'd299);
        #1 check("t4_ready_issue", ifa.req_ready, 0);
        @(negedge clk);
        check("t4_ready_gap", ifa.req_ready, 0);
        check("t4_busy_gap", a_busy, 1);
        @(negedge clk);
        check("t4_ready_idle", ifa.req_ready, 2'b01);
        check("t4_busy_idle", a_busy, 0);
        @(negedge clk);
        ifa.req_valid[0] = 1'b0;
        check("t4_stb2", a_stb, 1);
        check("t4_gid", a_gid, 0);
        check("t4_ch", a_ch, 7);
        check("t4_duty", a_duty, 299);
        repeat (2) @(negedge clk);

        // reset during ISSUE aborts the strobe and clears the rr pointer
        req_a(0, 1, 3'd1, 16'd10, 16'd5);
        @(posedge clk);
        #1 rst_n = 1'b0;
        ifa.req_valid[0] = 1'b0;
        req_a(1, 1, 3'd5, 16'd20, 16'd7);
        @(negedge clk);
        check("t5_stb", a_stb, 0);
        check("t5_err", a_err, 0);
        check("t5_busy", a_busy, 0);
        check("t5_ch", a_ch, 0);
        check("t5_per", a_per, 0);
        check("t5_duty", a_duty, 0);
        check("t5_gid", a_gid, 0);
        check("t5_ready_rst", ifa.req_ready, 0);
        rst_n = 1'b1;
        ifa.req_valid[0] = 1'b1;
        #1 check("t5_ptr_ready", ifa.req_ready, 2'b01);
        @(negedge clk);
        ifa.req_valid[0] = 1'b0;
        check("t5_stb0", a_stb, 1);
        check("t5_gid0", a_gid, 0);
        repeat (2) @(negedge clk);
        check("t5_ready1", ifa.req_ready, 2'b10);
        @(negedge clk);
        ifa.req_valid[1] = 1'b0;
        check("t5_stb1", a_stb, 1);
        check("t5_gid1", a_gid, 1);
        check("t5_ch1", a_ch, 5);
        check("t5_per1", a_per, 20);

        // four requesters, no gap: strobe every 2 cycles, order 0,1,2,3,0
        for (int i = 0; i < 4; i++) req_b(i, 1, 3'(i), 16'(100 + i), 16'(i));
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t6_stb_%0d", k), b_stb, k % 2);
            check($sformatf("t6_busy_%0d", k), b_busy, k % 2);
            if (k % 2 == 1) begin
                check($sformatf("t6_gid_%0d", k), b_gid, ((k - 1) / 2) % 4);
                check($sformatf("t6_ch_%0d", k), b_ch, ((k - 1) / 2) % 4);
                check($sformatf("t6_per_%0d", k), b_per, 100 + ((k - 1) / 2) % 4);
            end
            @(negedge clk);
        end
        ifb.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
